// File: rtl/nn_host_bridge_pkg.sv
// Shared definitions for the NeuralNetwork host bridge.
// Holds the memory-map widths, the host command opcodes, the bridge
// FSM state type and a helper that says which states take host bytes.
package nn_host_bridge_pkg;

    localparam int unsigned MM_DEPTH = 17;  // NN address width
    localparam int unsigned MM_SIZE  = 16;  // NN write data width
    localparam int unsigned Q_SIZE   = 16;  // NN read data width

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_BURST = 8'h42;

    typedef enum logic [3:0] {
        StIdle,
        StAddr0,
        StAddr1,
        StAddr2,
        StCount,
        StDhi,
        StDlo,
        StIssueWr,
        StIssueRd,
        StWaitRd,
        StTxHi,
        StTxLo
    } bridge_state_t;

    // States in which a host byte may be consumed.
    function automatic logic state_accepts(input bridge_state_t s);
        return s inside {StIdle, StAddr0, StAddr1, StAddr2, StCount, StDhi, StDlo};
    endfunction

endpackage

// File: rtl/nn_host_bridge_if.sv
// Bundle of the host byte link and the NN memory-mapped port.
//   master: the bridge (drives in_ready, out_*, write_*, read_addr, cmd_error)
//   slave : host transport + NN top (drives in_data/in_valid, out_ready,
//           read_data, busy)
interface nn_host_bridge_if
    import nn_host_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = MM_DEPTH,
    parameter int unsigned DATA_W  = MM_SIZE,
    parameter int unsigned RDATA_W = Q_SIZE
) ();

    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic               write_enable;
    logic [ADDR_W-1:0]  write_addr;
    logic [DATA_W-1:0]  write_data;
    logic [ADDR_W-1:0]  read_addr;
    logic [RDATA_W-1:0] read_data;
    logic               busy;
    logic               cmd_error;

    modport master (
        input  in_data, in_valid, out_ready, read_data, busy,
        output in_ready, out_data, out_valid, write_enable, write_addr, write_data,
        output read_addr, cmd_error
    );

    modport slave (
        output in_data, in_valid, out_ready, read_data, busy,
        input  in_ready, out_data, out_valid, write_enable, write_addr, write_data,
        input  read_addr, cmd_error
    );

endinterface

// File: rtl/nn_byte_packer.sv
// Assembles host bytes into a 24-bit address field and a 16-bit data field.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low clear
//   we_i            store byte_i this cycle
//   sel_data_i      1: target the data field, 0: the address field
//   idx_i           byte lane (2 = addr MSB ... 0 = LSB; data uses 1/0)
//   byte_i          byte being accepted
//   addr_o, data_o  field contents including the byte stored this cycle,
//                   so the caller can act on a complete field in the same
//                   cycle its last byte arrives
module nn_byte_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic        sel_data_i,
    input  logic [1:0]  idx_i,
    input  logic [7:0]  byte_i,
    output logic [23:0] addr_o,
    output logic [15:0] data_o
);

    logic [23:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (we_i) begin
            if (sel_data_i) begin
                if (idx_i[0]) data_d[15:8] = byte_i;
                else          data_d[7:0]  = byte_i;
            end else begin
                case (idx_i)
                    2'd2:    addr_d[23:16] = byte_i;
                    2'd1:    addr_d[15:8]  = byte_i;
                    default: addr_d[7:0]   = byte_i;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign addr_o = addr_d;
    assign data_o = data_d;

endmodule

// File: rtl/nn_host_bridge.sv
// Host-side initiator for the NeuralNetwork memory-mapped port.
// Parses WRITE (57 a a a d d), READ (52 a a a) and BURST (42 a a a N d d ...)
// frames from the host byte stream, issues write strobes / timed reads while
// honouring busy, and returns read results as two big-endian bytes.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    nn_host_bridge_if.master (host byte link + NN port + cmd_error)
module nn_host_bridge
    import nn_host_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W   = MM_DEPTH,
    parameter int unsigned DATA_W   = MM_SIZE,
    parameter int unsigned RDATA_W  = Q_SIZE,
    parameter int unsigned READ_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    nn_host_bridge_if.master bus
);

    bridge_state_t     state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [8:0]        word_cnt_q, word_cnt_d;
    logic [7:0]        lat_cnt_q, lat_cnt_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              cmd_err_q, cmd_err_d;

    logic        in_ready_c, fire, we_c, out_valid_c;
    logic [7:0]  out_data_c;
    logic        pk_we, pk_sel_data;
    logic [1:0]  pk_idx;
    logic [23:0] pk_addr;
    logic [15:0] pk_data;

    nn_byte_packer u_packer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .we_i       (pk_we),
        .sel_data_i (pk_sel_data),
        .idx_i      (pk_idx),
        .byte_i     (bus.in_data),
        .addr_o     (pk_addr),
        .data_o     (pk_data)
    );

    assign in_ready_c = reset && state_accepts(state_q);
    assign fire       = bus.in_valid && in_ready_c;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_cnt_d  = addr_cnt_q;
        word_cnt_d  = word_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        rdata_d     = rdata_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        cmd_err_d   = 1'b0;
        we_c        = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = 8'h00;
        pk_we       = 1'b0;
        pk_sel_data = 1'b0;
        pk_idx      = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    if (bus.in_data inside {OP_WRITE, OP_READ, OP_BURST}) begin
                        op_d    = bus.in_data;
                        state_d = StAddr0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StAddr0: begin
                pk_we  = fire;
                pk_idx = 2'd2;
                if (fire) state_d = StAddr1;
            end
            StAddr1: begin
                pk_we  = fire;
                pk_idx = 2'd1;
                if (fire) state_d = StAddr2;
            end
            StAddr2: begin
                pk_we  = fire;
                pk_idx = 2'd0;
                if (fire) begin
                    // Upper address bits beyond ADDR_W are dropped by the cast.
                    addr_cnt_d = ADDR_W'(pk_addr);
                    if (op_q == OP_READ) begin
                        rd_addr_d = ADDR_W'(pk_addr);
                        state_d   = StIssueRd;
                    end else if (op_q == OP_BURST) begin
                        state_d = StCount;
                    end else begin
                        state_d = StDhi;
                    end
                end
            end
            StCount: begin
                if (fire) begin
                    word_cnt_d = (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
                    state_d    = StDhi;
                end
            end
            StDhi: begin
                pk_we       = fire;
                pk_sel_data = 1'b1;
                pk_idx      = 2'd1;
                if (fire) state_d = StDlo;
            end
            StDlo: begin
                pk_we       = fire;
                pk_sel_data = 1'b1;
                pk_idx      = 2'd0;
                if (fire) begin
                    // Load the write port now so it is stable for the strobe cycle.
                    wr_addr_d = addr_cnt_q;
                    wr_data_d = DATA_W'(pk_data);
                    state_d   = StIssueWr;
                end
            end
            StIssueWr: begin
                if (!bus.busy) begin
                    we_c = 1'b1;
                    if (op_q == OP_BURST) begin
                        addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                        word_cnt_d = word_cnt_q - 9'd1;
                        state_d    = (word_cnt_q == 9'd1) ? StIdle : StDhi;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StIssueRd: begin
                if (!bus.busy) begin
                    lat_cnt_d = 8'(READ_LAT - 1);
                    state_d   = StWaitRd;
                end
            end
            StWaitRd: begin
                if (lat_cnt_q == 8'd0) begin
                    rdata_d = 16'(bus.read_data);
                    state_d = StTxHi;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            StTxHi: begin
                out_valid_c = 1'b1;
                out_data_c  = rdata_q[15:8];
                if (bus.out_ready) state_d = StTxLo;
            end
            StTxLo: begin
                out_valid_c = 1'b1;
                out_data_c  = rdata_q[7:0];
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_q       <= 8'h00;
            addr_cnt_q <= '0;
            word_cnt_q <= '0;
            lat_cnt_q  <= '0;
            rdata_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_cnt_q <= addr_cnt_d;
            word_cnt_q <= word_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            rdata_q    <= rdata_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_data     = out_data_c;
    assign bus.write_enable = we_c;
    assign bus.write_addr   = wr_addr_q;
    assign bus.write_data   = wr_data_q;
    assign bus.read_addr    = rd_addr_q;
    assign bus.cmd_error    = cmd_err_q;

endmodule

// File: tb/tb_nn_host_bridge.sv
// Directed bench for nn_host_bridge: a vector table of host frames with
// expected write strobes, error pulses and response bytes, followed by
// hand-written sequences for reset, busy gating and output back-pressure.
module tb_nn_host_bridge;
    import nn_host_bridge_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nn_host_bridge_if bus ();

    nn_host_bridge #(.READ_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // NN read model: data appears one cycle after the address.
    function automatic logic [15:0] mem_model(input logic [16:0] a);
        if (a == 17'h00001) return 16'h1234;
        return {a[7:0], ~a[7:0]};
    endfunction
    always @(posedge clk) bus.read_data <= mem_model(bus.read_addr);

    // Observer, sampled mid-cycle.
    logic [16:0] mon_wa[$];
    logic [15:0] mon_wd[$];
    int          mon_wcyc[$];
    logic [7:0]  mon_ob[$];
    int          mon_err = 0;
    int          first_out_cyc = -1;

    always @(negedge clk) begin
        if (bus.write_enable === 1'b1) begin
            mon_wa.push_back(bus.write_addr);
            mon_wd.push_back(bus.write_data);
            mon_wcyc.push_back(cyc);
        end
        if (bus.cmd_error === 1'b1) mon_err = mon_err + 1;
        if (bus.out_valid === 1'b1 && first_out_cyc < 0) first_out_cyc = cyc;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) mon_ob.push_back(bus.out_data);
    end

    int n_pass = 0;
    int n_total = 0;
    int last_acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic clear_mon();
        mon_wa.delete();
        mon_wd.delete();
        mon_wcyc.delete();
        mon_ob.delete();
        mon_err = 0;
        first_out_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        bit  done = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                last_acc_cyc = cyc;
                done = 1'b1;
            end else if (++n > 200) begin
                n_total++;
                $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles", b, n);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] q_wa(input int k);
        return (k < mon_wa.size()) ? 32'(mon_wa[k]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_wd(input int k);
        return (k < mon_wd.size()) ? 32'(mon_wd[k]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_ob(input int k);
        return (k < mon_ob.size()) ? 32'(mon_ob[k]) : 32'hDEAD_BEEF;
    endfunction

    typedef struct packed {
        int               nb;
        logic [127:0]     bs;     // nb bytes, right-aligned, first byte most significant
        int               n_wr;
        logic [2:0][16:0] wa;     // wa[0] is the first strobe
        logic [2:0][15:0] wd;
        int               n_err;
        int               n_out;
        logic [15:0]      ob;     // response, high byte first
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nb: 6, bs: 128'h57_00_40_02_02_00, n_wr: 1,
                    wa: {17'h0, 17'h0, 17'h04002}, wd: {16'h0, 16'h0, 16'h0200},
                    n_err: 0, n_out: 0, ob: 16'h0};
        vecs[1] = '{nb: 11, bs: 128'h42_00_40_06_03_00_78_00_C8_02_00, n_wr: 3,
                    wa: {17'h04008, 17'h04007, 17'h04006}, wd: {16'h0200, 16'h00C8, 16'h0078},
                    n_err: 0, n_out: 0, ob: 16'h0};
        vecs[2] = '{nb: 4, bs: 128'h52_00_00_01, n_wr: 0,
                    wa: '0, wd: '0, n_err: 0, n_out: 2, ob: 16'h1234};
        vecs[3] = '{nb: 7, bs: 128'hFF_57_00_40_02_02_00, n_wr: 1,
                    wa: {17'h0, 17'h0, 17'h04002}, wd: {16'h0, 16'h0, 16'h0200},
                    n_err: 1, n_out: 0, ob: 16'h0};
        vecs[4] = '{nb: 6, bs: 128'h57_FF_FF_FF_AB_CD, n_wr: 1,
                    wa: {17'h0, 17'h0, 17'h1FFFF}, wd: {16'h0, 16'h0, 16'hABCD},
                    n_err: 0, n_out: 0, ob: 16'h0};
        vecs[5] = '{nb: 9, bs: 128'h42_01_FF_FF_02_11_11_22_22, n_wr: 2,
                    wa: {17'h0, 17'h00000, 17'h1FFFF}, wd: {16'h0, 16'h2222, 16'h1111},
                    n_err: 0, n_out: 0, ob: 16'h0};
        vecs[6] = '{nb: 4, bs: 128'h52_00_00_05, n_wr: 0,
                    wa: '0, wd: '0, n_err: 0, n_out: 2, ob: 16'h05FA};
        vecs[7] = '{nb: 1, bs: 128'h00, n_wr: 0,
                    wa: '0, wd: '0, n_err: 1, n_out: 0, ob: 16'h0};

        // Reset state, with a byte offered while reset is held.
        reset         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = OP_WRITE;
        bus.out_ready = 1'b1;
        bus.busy      = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst_in_ready",     32'(bus.in_ready),     32'h0);
        check("rst_write_enable", 32'(bus.write_enable), 32'h0);
        check("rst_write_addr",   32'(bus.write_addr),   32'h0);
        check("rst_write_data",   32'(bus.write_data),   32'h0);
        check("rst_read_addr",    32'(bus.read_addr),    32'h0);
        check("rst_out_valid",    32'(bus.out_valid),    32'h0);
        check("rst_out_data",     32'(bus.out_data),     32'h0);
        check("rst_cmd_error",    32'(bus.cmd_error),    32'h0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            for (int j = 0; j < vecs[i].nb; j++)
                send_byte(vecs[i].bs[8*(vecs[i].nb-1-j) +: 8]);
            idle(25);
            check($sformatf("v%0d_wr_count", i), 32'(mon_wa.size()), 32'(vecs[i].n_wr));
            for (int k = 0; k < vecs[i].n_wr; k++) begin
                check($sformatf("v%0d_wr%0d_addr", i, k), q_wa(k), 32'(vecs[i].wa[k]));
                check($sformatf("v%0d_wr%0d_data", i, k), q_wd(k), 32'(vecs[i].wd[k]));
            end
            if (vecs[i].n_wr > 0)
                check($sformatf("v%0d_wr_latency", i),
                      (mon_wcyc.size() > 0) ? 32'(mon_wcyc[mon_wcyc.size()-1]) : 32'hDEAD_BEEF,
                      32'(last_acc_cyc + 1));
            check($sformatf("v%0d_err_count", i), 32'(mon_err), 32'(vecs[i].n_err));
            check($sformatf("v%0d_out_count", i), 32'(mon_ob.size()), 32'(vecs[i].n_out));
            for (int k = 0; k < vecs[i].n_out; k++)
                check($sformatf("v%0d_out%0d", i, k), q_ob(k),
                      32'((k == 0) ? vecs[i].ob[15:8] : vecs[i].ob[7:0]));
            if (vecs[i].n_out > 0)
                check($sformatf("v%0d_rd_latency", i), 32'(first_out_cyc), 32'(last_acc_cyc + 3));
            @(negedge clk);
            check($sformatf("v%0d_back_idle", i), 32'(bus.in_ready), 32'h1);
            @(posedge clk);
            #1;
        end

        // Read with host back-pressure: high byte must hold while stalled.
        begin
            int t = 0;
            clear_mon();
            bus.out_ready = 1'b0;
            send_byte(8'h52);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h01);
            do begin
                @(negedge clk);
                t++;
            end while (bus.out_valid !== 1'b1 && t < 50);
            if (bus.out_valid !== 1'b1) begin
                n_total++;
                $display("FAIL stall_wait: out_valid not seen within %0d cycles", t);
            end
            for (int s = 0; s < 5; s++) begin
                check($sformatf("stall_hold%0d", s),
                      {23'h0, bus.out_valid, bus.out_data}, {23'h0, 1'b1, 8'h12});
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            idle(10);
            check("stall_out_count", 32'(mon_ob.size()), 32'd2);
            check("stall_out0", q_ob(0), 32'h12);
            check("stall_out1", q_ob(1), 32'h34);
        end

        // busy held for 10 cycles across a WRITE frame.
        begin
            int start;
            int fall_cyc;
            clear_mon();
            bus.busy = 1'b1;
            start = cyc;
            send_byte(8'h57);
            send_byte(8'h00);
            send_byte(8'h40);
            send_byte(8'h02);
            send_byte(8'h02);
            send_byte(8'h00);
            while (cyc - start < 10) idle(1);
            check("busy_no_strobe", 32'(mon_wa.size()), 32'd0);
            bus.busy = 1'b0;
            fall_cyc = cyc;
            idle(10);
            check("busy_strobe_count", 32'(mon_wa.size()), 32'd1);
            check("busy_strobe_cycle",
                  (mon_wcyc.size() > 0) ? 32'(mon_wcyc[0]) : 32'hDEAD_BEEF, 32'(fall_cyc));
            check("busy_strobe_addr", q_wa(0), 32'h04002);
            check("busy_strobe_data", q_wd(0), 32'h0200);
        end

        // Reset mid-frame, then a normal READ.
        clear_mon();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h40);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        idle(20);
        check("rstmid_no_write", 32'(mon_wa.size()), 32'd0);
        check("rstmid_out_count", 32'(mon_ob.size()), 32'd2);
        check("rstmid_out0", q_ob(0), 32'h12);
        check("rstmid_out1", q_ob(1), 32'h34);
        check("rstmid_err", 32'(mon_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
